rst_seq: RTL and testbench

Parametrised reset sequencer for the board top level. It replaces the fixed cold-reset counter with a full sequence: a power-on hold, a wait for N clock/calibration lock inputs to be stable, then staged release of NUM_CH per-domain resets (Ethernet ports, DB, DRAM front end). It re-sequences automatically on lock loss or on a soft-reset request, and sits between the clock primitives and the `eth_top`/`db_top` reset inputs.

---
 rtl/rst_seq_pkg.sv | 15 +
 rtl/rst_seq_sync_2ff.sv | 28 ++
 rtl/rst_seq.sv | 179 +++++++++++++++++
 tb/tb_rst_seq.sv | 374 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rst_seq_pkg.sv
// Shared types and constants for the rst_seq reset sequencer.
package rst_seq_pkg;

    typedef enum logic [1:0] {
        COLD,
        LOCK,
        REL,
        RUN
    } state_t;

    localparam int LOST_CNT_W       = 8;
    localparam int FAST_COLD_CYCLES = 10;
    localparam int FAST_LOCK_STABLE = 4;

endpackage

// File: rtl/rst_seq_sync_2ff.sv
// Two-flop synchronizer with asynchronous reset to a configurable value.
module sync_2ff #(
    parameter int                 WIDTH   = 1,
    parameter logic [WIDTH-1:0]   RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] sync_p0;
    logic [WIDTH-1:0] sync_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_p0 <= RST_VAL;
            sync_p1 <= RST_VAL;
        end else begin
            // stage 0 -> stage 1
            sync_p0 <= d;
            sync_p1 <= sync_p0;
        end
    end

    assign q = sync_p1;

endmodule

// File: rtl/rst_seq.sv
// Board reset sequencer: cold hold, lock qualification, staged channel release.
// Optional macro RST_SEQ_FAST_SIM_EN shortens the cold hold and lock window.
module rst_seq
    import rst_seq_pkg::*;
#(
    parameter int NUM_CH      = 8,
    parameter int NUM_LOCK    = 2,
    parameter int COLD_CYCLES = 16383,
    parameter int LOCK_STABLE = 64,
    parameter int GAP_CYCLES  = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_LOCK-1:0]   lock_in,
    input  logic                  soft_rst,
    output logic                  sys_rst,
    output logic [NUM_CH-1:0]     ch_rst,
    output logic                  ready,
    output logic [LOST_CNT_W-1:0] lost_cnt
);

`ifdef RST_SEQ_FAST_SIM_EN
    localparam int COLD_EFF = FAST_COLD_CYCLES;
    localparam int STAB_EFF = FAST_LOCK_STABLE;
`else
    localparam int COLD_EFF = COLD_CYCLES;
    localparam int STAB_EFF = LOCK_STABLE;
`endif

    localparam int COLD_W = $clog2(COLD_EFF + 1);
    localparam int STAB_W = $clog2(STAB_EFF + 1);
    localparam int GAP_W  = $clog2(GAP_CYCLES + 1);
    localparam int IDX_W  = $clog2(NUM_CH + 1);

    localparam logic [COLD_W-1:0] COLD_TGT = COLD_W'(COLD_EFF);
    localparam logic [STAB_W-1:0] STAB_TGT = STAB_W'(STAB_EFF);
    localparam logic [GAP_W-1:0]  GAP_TGT  = GAP_W'(GAP_CYCLES);
    localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(NUM_CH - 1);

    function automatic logic [LOST_CNT_W-1:0] sat_inc(input logic [LOST_CNT_W-1:0] v);
        return (v == {LOST_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    logic                rst_int;
    logic [NUM_LOCK-1:0] lock_sync;
    logic                all_lock;

    sync_2ff #(
        .WIDTH   (1),
        .RST_VAL (1'b1)
    ) u_rst_sync (
        .clk (clk),
        .rst (rst),
        .d   (1'b0),
        .q   (rst_int)
    );

    sync_2ff #(
        .WIDTH   (NUM_LOCK),
        .RST_VAL ('0)
    ) u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (lock_in),
        .q   (lock_sync)
    );

    assign all_lock = &lock_sync;

    state_t              state, state_nxt;
    logic [COLD_W-1:0]   cold_cnt, cold_nxt, cold_inc;
    logic [STAB_W-1:0]   stab_cnt, stab_nxt, stab_inc;
    logic [GAP_W-1:0]    gap_cnt, gap_nxt, gap_inc;
    logic [IDX_W-1:0]    idx, idx_nxt, idx_inc;
    logic                sys_nxt, ready_nxt;
    logic [NUM_CH-1:0]   ch_nxt;
    logic [LOST_CNT_W-1:0] lost_nxt;

    always_comb begin
        state_nxt = state;
        cold_nxt  = cold_cnt;
        stab_nxt  = stab_cnt;
        gap_nxt   = gap_cnt;
        idx_nxt   = idx;
        sys_nxt   = sys_rst;
        ch_nxt    = ch_rst;
        ready_nxt = ready;
        lost_nxt  = lost_cnt;
        cold_inc  = cold_cnt + 1'b1;
        stab_inc  = stab_cnt + 1'b1;
        gap_inc   = gap_cnt + 1'b1;
        idx_inc   = idx + 1'b1;

        if (soft_rst) begin
            state_nxt = COLD;
            cold_nxt  = '0;
            sys_nxt   = 1'b1;
            ch_nxt    = '1;
            ready_nxt = 1'b0;
        end else if ((state == REL || state == RUN) && !all_lock) begin
            state_nxt = LOCK;
            stab_nxt  = '0;
            sys_nxt   = 1'b1;
            ch_nxt    = '1;
            ready_nxt = 1'b0;
            lost_nxt  = sat_inc(lost_cnt);
        end else begin
            case (state)
                COLD: begin
                    cold_nxt = cold_inc;
                    if (cold_inc == COLD_TGT) begin
                        state_nxt = LOCK;
                        stab_nxt  = '0;
                    end
                end
                LOCK: begin
                    if (!all_lock) begin
                        stab_nxt = '0;
                    end else if (stab_inc == STAB_TGT) begin
                        // channels release lowest-first by shifting zeros in from bit 0
                        sys_nxt = 1'b0;
                        ch_nxt  = ch_rst << 1;
                        idx_nxt = '0;
                        gap_nxt = '0;
                        if (NUM_CH == 1) begin
                            state_nxt = RUN;
                            ready_nxt = 1'b1;
                        end else begin
                            state_nxt = REL;
                        end
                    end else begin
                        stab_nxt = stab_inc;
                    end
                end
                REL: begin
                    if (gap_inc == GAP_TGT) begin
                        gap_nxt = '0;
                        idx_nxt = idx_inc;
                        ch_nxt  = ch_rst << 1;
                        if (idx_inc == IDX_LAST) begin
                            state_nxt = RUN;
                            ready_nxt = 1'b1;
                        end
                    end else begin
                        gap_nxt = gap_inc;
                    end
                end
                RUN: begin
                end
                default: state_nxt = COLD;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst_int) begin
        if (rst_int) begin
            state    <= COLD;
            cold_cnt <= '0;
            stab_cnt <= '0;
            gap_cnt  <= '0;
            idx      <= '0;
            sys_rst  <= 1'b1;
            ch_rst   <= '1;
            ready    <= 1'b0;
            lost_cnt <= '0;
        end else begin
            state    <= state_nxt;
            cold_cnt <= cold_nxt;
            stab_cnt <= stab_nxt;
            gap_cnt  <= gap_nxt;
            idx      <= idx_nxt;
            sys_rst  <= sys_nxt;
            ch_rst   <= ch_nxt;
            ready    <= ready_nxt;
            lost_cnt <= lost_nxt;
        end
    end

endmodule

// File: tb/tb_rst_seq.sv
// Self-checking bench for rst_seq (NUM_CH=4, GAP=3, cold hold 10, lock window 4).
module tb_rst_seq;

    localparam int NCH  = 4;
    localparam int GAP  = 3;
    localparam int COLD = 10;
    localparam int STAB = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       soft_rst = 1'b0;
    logic [1:0] lock_in = 2'b11;
    logic       sys_rst;
    logic [3:0] ch_rst;
    logic       ready;
    logic [7:0] lost_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    rst_seq #(
        .NUM_CH      (NCH),
        .NUM_LOCK    (2),
        .COLD_CYCLES (COLD),
        .LOCK_STABLE (STAB),
        .GAP_CYCLES  (GAP)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .lock_in  (lock_in),
        .soft_rst (soft_rst),
        .sys_rst  (sys_rst),
        .ch_rst   (ch_rst),
        .ready    (ready),
        .lost_cnt (lost_cnt)
    );

    // Reference model: phase plus elapsed time since release; channel k is
    // out of reset once k*GAP cycles have passed since the first release.
    typedef enum {M_COLD, M_LOCK, M_ACT} mphase_t;
    mphase_t m_ph;
    int      m_cold, m_stab, m_el, m_lost, m_hold;
    logic    h0, h1;

    int         pu_edge [8] = '{15, 16, 18, 19, 21, 22, 24, 25};
    logic [5:0] pu_val  [8] = '{6'b1_1111_0, 6'b0_1110_0, 6'b0_1110_0, 6'b0_1100_0,
                                6'b0_1100_0, 6'b0_1000_0, 6'b0_1000_0, 6'b0_0000_1};

    task automatic model_reset();
        m_ph = M_COLD; m_cold = 0; m_stab = 0; m_el = 0; m_lost = 0;
        m_hold = 2; h0 = 1'b0; h1 = 1'b0;
    endtask

    task automatic model_edge();
        logic eff;
        eff = h1;
        if (rst) begin
            h0 = 1'b0; h1 = 1'b0;
            return;
        end
        h1 = h0;
        h0 = &lock_in;
        if (m_hold > 0) begin
            m_hold--;
            return;
        end
        if (soft_rst) begin
            m_ph = M_COLD; m_cold = 0;
        end else if (m_ph == M_ACT && !eff) begin
            m_ph = M_LOCK; m_stab = 0;
            if (m_lost < 255) m_lost++;
        end else begin
            case (m_ph)
                M_COLD: begin
                    m_cold++;
                    if (m_cold == COLD) begin m_ph = M_LOCK; m_stab = 0; end
                end
                M_LOCK: begin
                    m_stab = eff ? m_stab + 1 : 0;
                    if (m_stab == STAB) begin m_ph = M_ACT; m_el = 0; end
                end
                default: m_el++;
            endcase
        end
    endtask

    function automatic logic [13:0] exp_vec();
        logic [3:0] ch;
        logic       act;
        act = (m_ph == M_ACT);
        for (int k = 0; k < NCH; k++) ch[k] = !(act && m_el >= k * GAP);
        return {!act, ch, act && (m_el >= (NCH - 1) * GAP), m_lost[7:0]};
    endfunction

    function automatic logic [13:0] obs_vec();
        return {sys_rst, ch_rst, ready, lost_cnt};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic apply_rst(input logic [1:0] lk);
        lock_in = lk; soft_rst = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        lock_in = 2'b11; soft_rst = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        n_chk++;
        if (obs_vec() !== {1'b1, 4'hF, 1'b0, 8'h00})
            $display("FAIL reset_async got=%h want=%h", obs_vec(), {1'b1, 4'hF, 1'b0, 8'h00});
        else n_pass++;
        tick(); tick();
        rst = 1'b0;
        for (int n = 1; n <= 2; n++) begin
            tick();
            n_chk++;
            if (obs_vec() !== {1'b1, 4'hF, 1'b0, 8'h00})
                $display("FAIL reset_hold edge=%0d got=%h want=%h", n, obs_vec(), {1'b1, 4'hF, 1'b0, 8'h00});
            else n_pass++;
        end
    endtask

    task automatic test_power_up();
        apply_rst(2'b11);
        for (int n = 1; n <= 28; n++) begin
            tick();
            n_chk++;
            if (obs_vec() !== exp_vec())
                $display("FAIL pwr_model edge=%0d got=%h want=%h", n, obs_vec(), exp_vec());
            else n_pass++;
            for (int j = 0; j < 8; j++) begin
                if (n == pu_edge[j]) begin
                    n_chk++;
                    if ({sys_rst, ch_rst, ready} !== pu_val[j])
                        $display("FAIL pwr_seq edge=%0d got=%b want=%b", n, {sys_rst, ch_rst, ready}, pu_val[j]);
                    else n_pass++;
                end
            end
        end
        n_chk++;
        if (lost_cnt !== 8'd0) $display("FAIL pwr_lost got=%0d want=0", lost_cnt);
        else n_pass++;
    endtask

    task automatic test_late_lock();
        int t;
        apply_rst(2'b01);
        for (int n = 1; n <= 48; n++) begin
            tick();
            n_chk++;
            if (obs_vec() !== exp_vec())
                $display("FAIL late_model edge=%0d got=%h want=%h", n, obs_vec(), exp_vec());
            else n_pass++;
        end
        n_chk++;
        if ({sys_rst, ch_rst} !== 5'b1_1111) $display("FAIL late_hold got=%b want=11111", {sys_rst, ch_rst});
        else n_pass++;
        lock_in = 2'b11;
        t = 0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            n_chk++;
            if (obs_vec() !== exp_vec())
                $display("FAIL late_model2 k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
            else n_pass++;
            if (ch_rst[0] === 1'b0 && t == 0) t = k;
        end
        n_chk++;
        if (t != 6) $display("FAIL late_latency got=%0d want=6", t);
        else n_pass++;
    endtask

    task automatic test_lock_glitch();
        int t, g, w;
        apply_rst(2'b11);
        t = 0;
        for (int n = 1; n <= 30; n++) begin
            lock_in = (n == 14) ? 2'b01 : 2'b11;
            tick();
            n_chk++;
            if (obs_vec() !== exp_vec())
                $display("FAIL glitch_model edge=%0d got=%h want=%h", n, obs_vec(), exp_vec());
            else n_pass++;
            if (sys_rst === 1'b0 && t == 0) t = n;
        end
        n_chk++;
        if (t != 20) $display("FAIL glitch_release got=%0d want=20", t);
        else n_pass++;
        g = $urandom_range(11, 19);
        w = $urandom_range(1, 3);
        apply_rst(2'b11);
        for (int n = 1; n <= 35; n++) begin
            lock_in = (n >= g && n < g + w) ? 2'($urandom_range(0, 2)) : 2'b11;
            tick();
            n_chk++;
            if (obs_vec() !== exp_vec())
                $display("FAIL glitch_rand edge=%0d g=%0d w=%0d got=%h want=%h", n, g, w, obs_vec(), exp_vec());
            else n_pass++;
        end
        lock_in = 2'b11;
    endtask

    task automatic test_lock_loss_run();
        apply_rst(2'b11);
        for (int n = 1; n <= 30; n++) tick();
        lock_in = 2'b10;
        for (int k = 1; k <= 3; k++) begin
            tick();
            n_chk++;
            if (k < 3 && {sys_rst, ch_rst, ready, lost_cnt} !== {1'b0, 4'h0, 1'b1, 8'd0})
                $display("FAIL loss_early k=%0d got=%h want=%h", k, obs_vec(), {1'b0, 4'h0, 1'b1, 8'd0});
            else if (k == 3 && {sys_rst, ch_rst, ready, lost_cnt} !== {1'b1, 4'hF, 1'b0, 8'd1})
                $display("FAIL loss_assert got=%h want=%h", obs_vec(), {1'b1, 4'hF, 1'b0, 8'd1});
            else n_pass++;
        end
        lock_in = 2'b11;
        for (int k = 1; k <= 20; k++) begin
            tick();
            n_chk++;
            if (obs_vec() !== exp_vec())
                $display("FAIL loss_model k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
            else n_pass++;
            if (k == 6 || k == 15) begin
                n_chk++;
                if (k == 6 && {sys_rst, ch_rst, ready} !== 6'b0_1110_0)
                    $display("FAIL loss_rerel got=%b want=011100", {sys_rst, ch_rst, ready});
                else if (k == 15 && {ch_rst, ready, lost_cnt} !== {4'h0, 1'b1, 8'd1})
                    $display("FAIL loss_rerun got=%h want=%h", {ch_rst, ready, lost_cnt}, {4'h0, 1'b1, 8'd1});
                else n_pass++;
            end
        end
    endtask

    task automatic test_soft_rel();
        int t, hold;
        logic found;
        apply_rst(2'b11);
        for (int n = 1; n <= 30; n++) tick();
        lock_in = 2'b10;
        tick(); tick(); tick();
        lock_in = 2'b11;
        found = 1'b0;
        for (int k = 1; k <= 20 && !found; k++) begin
            tick();
            n_chk++;
            if (obs_vec() !== exp_vec())
                $display("FAIL soft_model k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
            else n_pass++;
            if (ch_rst === 4'b1110) found = 1'b1;
        end
        n_chk++;
        if (!found) $display("FAIL soft_reach_rel got=%b want=1110", ch_rst);
        else n_pass++;
        lock_in = 2'b10;
        tick(); tick();
        soft_rst = 1'b1;
        tick();
        n_chk++;
        if (obs_vec() !== {1'b1, 4'hF, 1'b0, 8'd1})
            $display("FAIL soft_cold got=%h want=%h", obs_vec(), {1'b1, 4'hF, 1'b0, 8'd1});
        else n_pass++;
        lock_in = 2'b11;
        hold = $urandom_range(0, 4);
        for (int k = 0; k < hold; k++) begin
            tick();
            n_chk++;
            if (obs_vec() !== exp_vec() || sys_rst !== 1'b1)
                $display("FAIL soft_hold k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
            else n_pass++;
        end
        soft_rst = 1'b0;
        t = 0;
        for (int k = 1; k <= 30; k++) begin
            tick();
            n_chk++;
            if (obs_vec() !== exp_vec())
                $display("FAIL soft_model2 k=%0d got=%h want=%h", k, obs_vec(), exp_vec());
            else n_pass++;
            if (sys_rst === 1'b0 && t == 0) t = k;
        end
        n_chk++;
        if (t != COLD + STAB) $display("FAIL soft_restart got=%0d want=%0d", t, COLD + STAB);
        else n_pass++;
    endtask

    task automatic test_async_rst();
        #2;
        rst = 1'b1;
        #1;
        n_chk++;
        if (obs_vec() !== {1'b1, 4'hF, 1'b0, 8'h00})
            $display("FAIL async_rst got=%h want=%h", obs_vec(), {1'b1, 4'hF, 1'b0, 8'h00});
        else n_pass++;
        model_reset();
        tick(); tick();
        rst = 1'b0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            n_chk++;
            if (obs_vec() !== exp_vec())
                $display("FAIL async_model edge=%0d got=%h want=%h", n, obs_vec(), exp_vec());
            else n_pass++;
        end
    endtask

    task automatic test_lost_sat();
        apply_rst(2'b11);
        for (int n = 1; n <= 16; n++) tick();
        for (int i = 0; i < 257; i++) begin
            for (int k = 0; k < 9; k++) begin
                lock_in = (k < 3) ? 2'b10 : 2'b11;
                tick();
                n_chk++;
                if (obs_vec() !== exp_vec())
                    $display("FAIL sat_model i=%0d k=%0d got=%h want=%h", i, k, obs_vec(), exp_vec());
                else n_pass++;
            end
        end
        n_chk++;
        if (lost_cnt !== 8'hFF) $display("FAIL sat_value got=%0d want=255", lost_cnt);
        else n_pass++;
    endtask

    task automatic test_random();
        apply_rst(2'b11);
        for (int n = 1; n <= 1500; n++) begin
            for (int b = 0; b < 2; b++)
                if ($urandom_range(0, 29) == 0) lock_in[b] = ~lock_in[b];
            soft_rst = ($urandom_range(0, 119) == 0);
            tick();
            n_chk++;
            if (obs_vec() !== exp_vec())
                $display("FAIL rand_model n=%0d got=%h want=%h", n, obs_vec(), exp_vec());
            else n_pass++;
        end
        soft_rst = 1'b0;
        lock_in = 2'b11;
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_late_lock();
        test_lock_glitch();
        test_lock_loss_run();
        test_soft_rel();
        test_async_rst();
        test_lost_sat();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog passed=%0d total=%0d", n_pass, n_chk);
        $fatal(1);
    end

endmodule
